period_meter: RTL

PERIOD_METER -- requirements
Module: period_meter

---
 rtl/period_meter_pkg.sv | 11 +
 rtl/sync_edge.sv | 37 +++
 rtl/period_meter.sv | 104 ++++++++++
 3 files changed

// File: rtl/period_meter_pkg.sv
// Shared definitions for the period meter: FSM state encoding and default timeout.
package period_meter_pkg;

  localparam int unsigned DEFAULT_TIMEOUT = 100_000_000;

  typedef enum logic {
    WAIT_FIRST = 1'b0,
    MEASURE    = 1'b1
  } state_t;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer followed by an edge register that emits one-cycle
// rise/fall strobes; usable for any asynchronous level input such as a button.
module sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;
  logic r_rise;
  logic r_fall;

  // Strobes are registered so the edge stage adds one fixed cycle of latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_sync1 <= d;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_rise  <= r_sync2 & ~r_prev;
      r_fall  <= ~r_sync2 & r_prev;
    end
  end

  assign rise = r_rise;
  assign fall = r_fall;

endmodule

// File: rtl/period_meter.sv
// Measures rising-to-rising period and high time of an asynchronous input in
// clk cycles, with a timeout when no rising edge arrives within TIMEOUT cycles.
module period_meter
  import period_meter_pkg::*;
#(
  parameter  int unsigned TIMEOUT = DEFAULT_TIMEOUT,
  localparam int          WIDTH   = $clog2(TIMEOUT + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sig_in,
  output logic [WIDTH-1:0] period_out,
  output logic [WIDTH-1:0] high_out,
  output logic             valid,
  output logic             timeout,
  output logic             locked
);

  localparam logic [WIDTH-1:0] LIMIT = WIDTH'(TIMEOUT - 1);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

  logic             w_rise;
  logic             w_fall;
  logic [WIDTH-1:0] w_cntPlusOne;
  logic             w_atLimit;

  state_t           r_state;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_highLat;
  logic             r_fellSeen;
  logic [WIDTH-1:0] r_period;
  logic [WIDTH-1:0] r_high;
  logic             r_valid;
  logic             r_timeout;
  logic             r_locked;

  sync_edge u_syncEdge (
    .clk   (clk),
    .reset (reset),
    .d     (sig_in),
    .rise  (w_rise),
    .fall  (w_fall)
  );

  // cnt never exceeds TIMEOUT-1, so cnt+1 always fits in WIDTH bits.
  assign w_cntPlusOne = r_cnt + ONE;
  assign w_atLimit    = (r_cnt == LIMIT);

  // r_fellSeen distinguishes "no fall this period" from a latched high time,
  // so a signal that stayed high reports high_out equal to period_out.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= WAIT_FIRST;
      r_cnt      <= '0;
      r_highLat  <= '0;
      r_fellSeen <= 1'b0;
      r_period   <= '0;
      r_high     <= '0;
      r_valid    <= 1'b0;
      r_timeout  <= 1'b0;
      r_locked   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        WAIT_FIRST: begin
          r_cnt <= '0;
          if (w_rise) begin
            r_state    <= MEASURE;
            r_timeout  <= 1'b0;
            r_fellSeen <= 1'b0;
          end
        end
        MEASURE: begin
          if (w_rise) begin
            r_period   <= w_cntPlusOne;
            r_high     <= r_fellSeen ? r_highLat : w_cntPlusOne;
            r_valid    <= 1'b1;
            r_locked   <= 1'b1;
            r_cnt      <= '0;
            r_fellSeen <= 1'b0;
          end else if (w_atLimit) begin
            r_timeout <= 1'b1;
            r_locked  <= 1'b0;
            r_state   <= WAIT_FIRST;
            r_cnt     <= '0;
          end else begin
            r_cnt <= w_cntPlusOne;
            if (w_fall) begin
              r_highLat  <= w_cntPlusOne;
              r_fellSeen <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign period_out = r_period;
  assign high_out   = r_high;
  assign valid      = r_valid;
  assign timeout    = r_timeout;
  assign locked     = r_locked;

endmodule
